song_reader: RTL and testbench
==============================

// Module: song_reader
// PURPOSE
//  Note sequencer directly downstream of the music-player control unit. It takes
//  play / reset_player / song, walks the selected song's note ROM one entry at a
//  time, and presents each {note, duration} to the note player with a one-cycle
//  new_note strobe. It returns song_done to the control unit when the song ends.
// PARAMETERS
//  SONG_BITS   4   song select width (16 songs)
//  IDX_BITS    5   note index width (NOTES = 2**IDX_BITS = 32 entries per song)
//  NOTE_BITS   6   note code width
//  DUR_BITS    6   duration width; duration 0 = end-of-song marker
// PORTS
//  clk           in   1                    system clock, all state on rising edge
//  reset         in   1                    async, active-LOW; low = reset
//  play          in   1                    1 = advance, 0 = pause in place
//  reset_player  in   1                    sync restart of the song from index 0
//  song          in   SONG_BITS            selected song
//  note_done     in   1                    note player finished the current note
//  rom_addr      out  SONG_BITS+IDX_BITS   {song, idx}, combinational
//  rom_data      in   NOTE_BITS+DUR_BITS   {note, duration}, valid 1 clk after rom_addr
//  note          out  NOTE_BITS            registered note code
//  duration      out  DUR_BITS             registered duration
//  new_note      out  1                    1-cycle strobe: note/duration are new
//  song_done     out  1                    1-cycle strobe: song finished
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, idx=0, note=0, duration=0, new_note=0,
//   song_done=0.
//  Priority per clock: async reset > reset_player > play-gated FSM step.
//  reset_player=1: idx<=0, state<=IDLE, note/duration<=0. new_note is 0 in that
//   cycle. song_done is still 1 if the current state is DONE (Moore output).
//  FSM. States not listed below hold when play=0.
//   IDLE   : play=1 -> FETCH.
//   FETCH  : rom_addr={song,idx} already driven; -> LATCH.
//   LATCH  : rom_data valid. If duration field==0 -> DONE, registers unchanged.
//            Otherwise note/duration<=rom_data -> ISSUE.
//   ISSUE  : new_note=1 for exactly this cycle -> WAIT.
//   WAIT   : on note_done=1 & play=1: if idx==NOTES-1 -> DONE, else idx<=idx+1
//            -> FETCH. With play=0, note_done is ignored and the state holds.
//   DONE   : song_done=1 for this cycle -> IDLE, idx<=0. DONE is exited even if
//            play=0.
//  Latency: play rising in IDLE -> new_note 3 clocks later (FETCH, LATCH, ISSUE).
//   note_done -> next new_note 3 clocks later.
//  note_done outside WAIT is ignored. This includes the ISSUE cycle.
//  idx never wraps silently. Reaching NOTES-1 always ends via DONE.
//  Pause in FETCH/LATCH: rom_addr stays stable, so rom_data remains valid on resume.
//  Song change mid-song: the control unit pulses reset_player; song_reader restarts
//   at idx 0 of the new song. note/duration hold their last values while paused.
//  Reset asserted mid-note clears everything immediately, with no strobes.
// TESTING
//  1. Reset low, then high with play=0 -> all outputs 0, rom_addr={song,5'd0}, stays IDLE.
//  2. song=3, play=1, ROM[3][0]={6'd12,6'd8} -> new_note on 3rd clk, note=12, dur=8.
//  3. 32 non-zero entries, note_done 5 clk after each new_note -> 32 new_note
//     pulses, then one song_done; reset_player the same clk -> IDLE, idx=0.
//  4. ROM[3][2].duration=0 -> after 2 notes, song_done pulses, no 3rd new_note.
//  5. play=0 in WAIT with note_done=1 -> no advance. play=1 with note_done=1 ->
//     FETCH, next note issued 3 clk later.
//  6. reset_player mid-WAIT at idx=7 -> IDLE, idx=0, note=0. With play=1 ->
//     ROM[song][0] issued. Reset low in ISSUE -> new_note drops the same cycle.

Source files
------------

// File: rtl/song_reader.sv
// song_reader: walks a song's note ROM and hands each
// {note, duration} to the note player with a one-cycle strobe.
module song_reader #(
  parameter int SONG_BITS = 4,
  parameter int IDX_BITS  = 5,
  parameter int NOTE_BITS = 6,
  parameter int DUR_BITS  = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic                          reset_player,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [NOTE_BITS+DUR_BITS-1:0] rom_data,
  output logic [NOTE_BITS-1:0]          note,
  output logic [DUR_BITS-1:0]           duration,
  output logic                          new_note,
  output logic                          song_done
);

  localparam int NOTES = 2 ** IDX_BITS;
  localparam logic [IDX_BITS-1:0] LAST =
    IDX_BITS'(NOTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [IDX_BITS-1:0]   r_idx;
  logic [NOTE_BITS-1:0]  r_note;
  logic [DUR_BITS-1:0]   r_dur;
  logic                  r_issue;
  logic                  r_done;

  logic [NOTE_BITS-1:0]  w_note;
  logic [DUR_BITS-1:0]   w_dur;
  logic                  w_last;

  assign w_dur  = rom_data[DUR_BITS-1:0];
  assign w_note =
    rom_data[NOTE_BITS+DUR_BITS-1:DUR_BITS];
  assign w_last = (r_idx == LAST);

  assign rom_addr  = {song, r_idx};
  assign note      = r_note;
  assign duration  = r_dur;
  // A restart cycle never announces a note.
  assign new_note  = r_issue & ~reset_player;
  assign song_done = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_note  <= '0;
      r_dur   <= '0;
      r_issue <= 1'b0;
      r_done  <= 1'b0;
    end else if (reset_player) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_note  <= '0;
      r_dur   <= '0;
      r_issue <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_issue <= 1'b0;
      r_done  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (play) begin
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (play) begin
            r_state <= S_LATCH;
          end
        end
        S_LATCH: begin
          if (play) begin
            if (w_dur == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_note  <= w_note;
              r_dur   <= w_dur;
              r_state <= S_ISSUE;
              r_issue <= 1'b1;
            end
          end
        end
        // Strobe is exactly one cycle wide.
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (play && note_done) begin
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + IDX_BITS'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed stimulus with a queued
// scoreboard checked by an independent output monitor.
module tb_song_reader;

  logic        clk;
  logic        reset;
  logic        play;
  logic        reset_player;
  logic [3:0]  song;
  logic        note_done;
  logic [8:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] mem [512];

  typedef struct packed {
    logic       done;
    logic [5:0] n;
    logic [5:0] d;
  } exp_t;

  exp_t q[$];
  int   errors;
  int   checks;

  song_reader dut (
    .clk          (clk),
    .reset        (reset),
    .play         (play),
    .reset_player (reset_player),
    .song         (song),
    .note_done    (note_done),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .note         (note),
    .duration     (duration),
    .new_note     (new_note),
    .song_done    (song_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  function automatic void chk(
    string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp_v);
    end
  endfunction

  function automatic void push(
    bit dn, int n, int d);
    exp_t e;
    e.done = dn;
    e.n    = 6'(n);
    e.d    = 6'(d);
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (new_note === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_new_note", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_kind_note", 0, int'(e.done));
          chk("sb_note", int'(note), int'(e.n));
          chk("sb_dur", int'(duration), int'(e.d));
        end
      end
      if (song_done === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_song_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sb_kind_done", 1, int'(e.done));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(
    input bit want_done,
    input bit pulse,
    output int cnt);
    bit seen;
    note_done = pulse;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 20) begin
      tick();
      cnt++;
      note_done = 1'b0;
      seen = want_done ? song_done : new_note;
    end
  endtask

  function automatic int na(int s, int i);
    return s * 32 + i;
  endfunction

  initial begin
    int c;
    errors       = 0;
    checks       = 0;
    reset        = 1'b0;
    play         = 1'b0;
    reset_player = 1'b0;
    song         = 4'd3;
    note_done    = 1'b0;
    for (int a = 0; a < 512; a++) mem[a] = '0;
    mem[na(3, 0)] = {6'd12, 6'd8};
    mem[na(3, 1)] = {6'd20, 6'd3};
    mem[na(3, 2)] = {6'd33, 6'd0};
    for (int i = 0; i < 32; i++)
      mem[na(5, i)] = {6'(i + 10), 6'(i + 1)};

    // reset state
    tick();
    tick();
    chk("rst_note", int'(note), 0);
    chk("rst_dur", int'(duration), 0);
    chk("rst_new_note", int'(new_note), 0);
    chk("rst_song_done", int'(song_done), 0);
    chk("rst_addr", int'(rom_addr), 96);
    reset = 1'b1;
    repeat (4) tick();
    chk("idle_addr", int'(rom_addr), 96);
    chk("idle_new_note", int'(new_note), 0);

    // first note of song 3
    play = 1'b1;
    push(0, 12, 8);
    run_to(0, 0, c);
    chk("lat_first", c, 3);
    chk("first_note", int'(note), 12);
    chk("first_dur", int'(duration), 8);
    tick();
    tick();
    push(0, 20, 3);
    run_to(0, 1, c);
    chk("lat_second", c, 3);

    // end marker at index 2
    repeat (3) tick();
    push(1, 0, 0);
    run_to(1, 1, c);
    chk("lat_marker_done", c, 3);
    chk("marker_note_hold", int'(note), 20);
    chk("marker_dur_hold", int'(duration), 3);
    play = 1'b0;
    tick();
    chk("after_done_sd", int'(song_done), 0);
    chk("after_done_addr", int'(rom_addr), 96);
    repeat (3) tick();

    // pause in WAIT ignores note_done
    play = 1'b1;
    push(0, 12, 8);
    run_to(0, 0, c);
    chk("lat_replay", c, 3);
    tick();
    play      = 1'b0;
    note_done = 1'b1;
    repeat (3) tick();
    chk("pause_addr", int'(rom_addr), 96);
    chk("pause_note", int'(note), 12);
    play = 1'b1;
    push(0, 20, 3);
    run_to(0, 1, c);
    chk("lat_resume", c, 3);
    tick();
    play         = 1'b0;
    reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    chk("rp_note", int'(note), 0);
    chk("rp_addr", int'(rom_addr), 96);

    // full 32-note song 5
    song = 4'd5;
    tick();
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push(0, i + 10, i + 1);
      if (i == 0) begin
        run_to(0, 0, c);
      end else begin
        repeat (4) tick();
        run_to(0, 1, c);
      end
      chk("lat_full", c, 3);
    end
    repeat (4) tick();
    push(1, 0, 0);
    run_to(1, 1, c);
    chk("lat_full_done", c, 1);
    reset_player = 1'b1;
    play         = 1'b0;
    tick();
    reset_player = 1'b0;
    chk("full_rp_addr", int'(rom_addr), 160);
    chk("full_rp_note", int'(note), 0);
    chk("full_rp_sd", int'(song_done), 0);
    repeat (3) tick();

    // restart mid-WAIT at index 7
    play = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(0, i + 10, i + 1);
      if (i == 0) begin
        run_to(0, 0, c);
      end else begin
        tick();
        run_to(0, 1, c);
      end
      chk("lat_mid", c, 3);
    end
    tick();
    chk("mid_addr", int'(rom_addr), 167);
    reset_player = 1'b1;
    tick();
    reset_player = 1'b0;
    chk("mid_rp_note", int'(note), 0);
    chk("mid_rp_dur", int'(duration), 0);
    chk("mid_rp_addr", int'(rom_addr), 160);
    push(0, 10, 1);
    run_to(0, 0, c);
    chk("lat_restart", c, 3);
    tick();
    run_to(0, 1, c);
    chk("lat_pre_reset", c, 3);
    chk("pre_reset_note", int'(note), 11);

    // async reset during ISSUE
    #2;
    reset = 1'b0;
    #1;
    chk("areset_new_note", int'(new_note), 0);
    chk("areset_note", int'(note), 0);
    chk("areset_dur", int'(duration), 0);
    chk("areset_addr", int'(rom_addr), 160);
    play = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("sb_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

endmodule
